// File: rtl/inst_stream_feeder.sv
// inst_stream_feeder: instruction queue between the fetch source and decode.
//   It tags each filled instruction with a sequential PC and hands decode up to
//   FETCH_WIDTH in-order instructions per cycle.
// Latency: an instruction filled at edge t appears on out_* in the cycle after t.
//   Fill never bypasses to the output in the same cycle.
// Backpressure: fill_ready depends only on the registered count. A fill offered
//   while not ready is dropped, and the source must hold it. Decode takes the
//   whole valid group or nothing.
//
// Ports:
//   clk, rst          clock and synchronous active-low reset
//   fill_valid/_inst/_mask/_ready   fill group in; the mask is contiguous from bit 0
//   redirect_valid/_pc              flush the queue and restart the PC
//   out_valid/_inst/_pc/_ready      in-order group to decode
//   occupancy                       current entry count
//   perf_empty_cycles/_stall_cycles performance counters
//
// Optional build macro FEEDER_PERF_EN adds saturating performance counters.
// Without the macro, both perf ports read 0.
module inst_stream_feeder #(
  parameter int unsigned FETCH_WIDTH = 2,
  parameter int unsigned DEPTH       = 16,
  parameter logic [31:0] RESET_PC    = 32'hBFC00000
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      fill_valid,
  input  logic [32*FETCH_WIDTH-1:0] fill_inst,
  input  logic [FETCH_WIDTH-1:0]    fill_mask,
  output logic                      fill_ready,
  input  logic                      redirect_valid,
  input  logic [31:0]               redirect_pc,
  output logic [FETCH_WIDTH-1:0]    out_valid,
  output logic [32*FETCH_WIDTH-1:0] out_inst,
  output logic [32*FETCH_WIDTH-1:0] out_pc,
  input  logic                      out_ready,
  output logic [$clog2(DEPTH):0]    occupancy,
  output logic [31:0]               perf_empty_cycles,
  output logic [31:0]               perf_stall_cycles
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  // Room for one full group must exist before the dequeue in the same cycle.
  localparam logic [CW-1:0] FILL_LIMIT = CW'(DEPTH - FETCH_WIDTH);
  localparam logic [CW-1:0] FW_C       = CW'(FETCH_WIDTH);

  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic [31:0]   next_pc_q, next_pc_d;

  logic [31:0] inst_q [DEPTH];
  logic [31:0] inst_d [DEPTH];
  logic [31:0] pc_q   [DEPTH];
  logic [31:0] pc_d   [DEPTH];

  logic [CW-1:0] fill_n;
  logic [CW-1:0] deq_m;
  logic          enq;
  logic          deq;
  logic [PW-1:0] wr_idx;
  logic [PW-1:0] rd_idx;

  assign fill_ready = (count_q <= FILL_LIMIT);
  assign occupancy  = count_q;

  // The mask is contiguous, so its popcount is also the number of leading slots.
  always_comb begin
    fill_n = '0;
    for (int k = 0; k < FETCH_WIDTH; k++) begin
      fill_n = fill_n + CW'(fill_mask[k]);
    end
  end

  assign enq   = fill_valid && fill_ready && !redirect_valid;
  assign deq   = out_ready && out_valid[0] && !redirect_valid;
  assign deq_m = (count_q < FW_C) ? count_q : FW_C;

  // Next-state computation for pointers, count, PC and storage.
  always_comb begin
    head_d    = head_q;
    tail_d    = tail_q;
    count_d   = count_q;
    next_pc_d = next_pc_q;
    inst_d    = inst_q;
    pc_d      = pc_q;
    wr_idx    = '0;
    if (redirect_valid) begin
      head_d    = '0;
      tail_d    = '0;
      count_d   = '0;
      next_pc_d = redirect_pc;
    end else begin
      if (enq) begin
        for (int k = 0; k < FETCH_WIDTH; k++) begin
          if (CW'(k) < fill_n) begin
            wr_idx         = tail_q + PW'(k);
            inst_d[wr_idx] = fill_inst[32*k +: 32];
            pc_d[wr_idx]   = next_pc_q + 32'(4*k);
          end
        end
        tail_d    = tail_q + fill_n[PW-1:0];
        next_pc_d = next_pc_q + (32'(fill_n) << 2);
      end
      if (deq) begin
        head_d = head_q + deq_m[PW-1:0];
      end
      count_d = count_q + (enq ? fill_n : '0) - (deq ? deq_m : '0);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= '0;
      next_pc_q <= RESET_PC;
    end else begin
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
      next_pc_q <= next_pc_d;
    end
  end

  // Entry contents need no reset. The count masks any stale slot.
  always_ff @(posedge clk) begin
    inst_q <= inst_d;
    pc_q   <= pc_d;
  end

  // Output slot i shows entry head+i. Empty slots are driven to zero.
  always_comb begin
    out_valid = '0;
    out_inst  = '0;
    out_pc    = '0;
    rd_idx    = '0;
    for (int i = 0; i < FETCH_WIDTH; i++) begin
      rd_idx = head_q + PW'(i);
      if (count_q > CW'(i)) begin
        out_valid[i]       = 1'b1;
        out_inst[32*i +: 32] = inst_q[rd_idx];
        out_pc[32*i +: 32]   = pc_q[rd_idx];
      end
    end
  end

`ifdef FEEDER_PERF_EN
  logic [31:0] perf_empty_q;
  logic [31:0] perf_stall_q;

  // Both counters saturate. A redirect does not clear them.
  always_ff @(posedge clk) begin
    if (!rst) begin
      perf_empty_q <= '0;
      perf_stall_q <= '0;
    end else begin
      if ((count_q == '0) && (perf_empty_q != 32'hFFFFFFFF)) begin
        perf_empty_q <= perf_empty_q + 32'd1;
      end
      if (out_valid[0] && !out_ready && (perf_stall_q != 32'hFFFFFFFF)) begin
        perf_stall_q <= perf_stall_q + 32'd1;
      end
    end
  end

  assign perf_empty_cycles = perf_empty_q;
  assign perf_stall_cycles = perf_stall_q;
`else
  assign perf_empty_cycles = 32'h0;
  assign perf_stall_cycles = 32'h0;
`endif

endmodule

// File: tb/tb_inst_stream_feeder.sv
// Bench for inst_stream_feeder with FETCH_WIDTH=2 and DEPTH=16.
// It uses a table of vectors, hand sequences and random traffic.
// A queue-based model is checked every cycle.
module tb_inst_stream_feeder;
  localparam int          FW    = 2;
  localparam int          DEPTH = 16;
  localparam logic [31:0] RPC   = 32'hBFC00000;

`ifdef FEEDER_PERF_EN
  localparam logic [31:0] EXP_EMPTY = 32'd5;
  localparam logic [31:0] EXP_STALL = 32'd3;
`else
  localparam logic [31:0] EXP_EMPTY = 32'd0;
  localparam logic [31:0] EXP_STALL = 32'd0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        fill_valid;
  logic [63:0] fill_inst;
  logic [1:0]  fill_mask;
  logic        fill_ready;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [1:0]  out_valid;
  logic [63:0] out_inst;
  logic [63:0] out_pc;
  logic        out_ready;
  logic [4:0]  occupancy;
  logic [31:0] perf_empty_cycles;
  logic [31:0] perf_stall_cycles;

  always #5 clk = ~clk;

  inst_stream_feeder #(.FETCH_WIDTH(FW), .DEPTH(DEPTH), .RESET_PC(RPC)) dut (
    .clk(clk), .rst(rst),
    .fill_valid(fill_valid), .fill_inst(fill_inst), .fill_mask(fill_mask),
    .fill_ready(fill_ready),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_inst(out_inst), .out_pc(out_pc),
    .out_ready(out_ready), .occupancy(occupancy),
    .perf_empty_cycles(perf_empty_cycles), .perf_stall_cycles(perf_stall_cycles)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Reference model: a queue of (inst, pc) pairs plus the next PC.
  logic [31:0] mq_inst[$];
  logic [31:0] mq_pc[$];
  logic [31:0] m_npc;
  logic [31:0] m_empty;
  logic [31:0] m_stall;

  task automatic model_reset();
    mq_inst.delete();
    mq_pc.delete();
    m_npc   = RPC;
    m_empty = '0;
    m_stall = '0;
  endtask

  task automatic check_model(input string tag);
    logic [1:0]  ev;
    logic [63:0] ei;
    logic [63:0] ep;
    ev = '0; ei = '0; ep = '0;
    for (int i = 0; i < FW; i++) begin
      if (i < mq_pc.size()) begin
        ev[i]          = 1'b1;
        ei[32*i +: 32] = mq_inst[i];
        ep[32*i +: 32] = mq_pc[i];
      end
    end
    chk({tag, " occupancy"}, 64'(occupancy), 64'(mq_pc.size()));
    chk({tag, " fill_ready"}, 64'(fill_ready), 64'(mq_pc.size() <= DEPTH - FW));
    chk({tag, " out_valid"}, 64'(out_valid), 64'(ev));
    chk({tag, " out_inst"}, out_inst, ei);
    chk({tag, " out_pc"}, out_pc, ep);
    chk({tag, " perf_empty"}, 64'(perf_empty_cycles), 64'(m_empty));
    chk({tag, " perf_stall"}, 64'(perf_stall_cycles), 64'(m_stall));
  endtask

  // Apply the rules for one clock edge using the current inputs.
  task automatic model_step();
    int sz;
    sz = mq_pc.size();
    if (!rst) begin
      model_reset();
      return;
    end
`ifdef FEEDER_PERF_EN
    if (sz == 0 && m_empty != 32'hFFFFFFFF) m_empty++;
    if (sz > 0 && !out_ready && m_stall != 32'hFFFFFFFF) m_stall++;
`endif
    if (redirect_valid) begin
      mq_inst.delete();
      mq_pc.delete();
      m_npc = redirect_pc;
      return;
    end
    if (out_ready && sz > 0) begin
      for (int i = 0; i < FW && i < sz; i++) begin
        void'(mq_inst.pop_front());
        void'(mq_pc.pop_front());
      end
    end
    if (fill_valid && sz <= DEPTH - FW) begin
      for (int k = 0; k < FW; k++) begin
        if (fill_mask[k]) begin
          mq_inst.push_back(fill_inst[32*k +: 32]);
          mq_pc.push_back(m_npc);
          m_npc = m_npc + 32'd4;
        end
      end
    end
  endtask

  // Check the pre-edge outputs, advance the model, then clock the DUT.
  // On return, time is 1 unit after the edge.
  task automatic tick(input string tag);
    #1;
    check_model(tag);
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic r, input logic fv, input logic [63:0] inst,
                       input logic [1:0] mask, input logic rv, input logic [31:0] rpc,
                       input logic ordy);
    rst = r; fill_valid = fv; fill_inst = inst; fill_mask = mask;
    redirect_valid = rv; redirect_pc = rpc; out_ready = ordy;
  endtask

  typedef struct {
    logic        r;
    logic        fv;
    logic [63:0] inst;
    logic [1:0]  mask;
    logic        rv;
    logic [31:0] rpc;
    logic        ordy;
    logic [1:0]  e_v;
    logic [4:0]  e_occ;
    logic        e_fr;
    logic [31:0] e_pc0;
    logic [31:0] e_pc1;
    logic [31:0] e_inst0;
  } vec_t;

  vec_t tbl[14];

  initial begin
    logic [1:0]  rmask;
    int          mk;
    logic [31:0] exp_pc0;

    // Expected outputs are those seen after the edge that applies each row.
    tbl[0]  = '{1'b0, 1'b0, 64'h0, 2'b00, 1'b0, 32'h0, 1'b1, 2'b00, 5'd0, 1'b1, 32'h0, 32'h0, 32'h0};
    tbl[1]  = '{1'b1, 1'b1, 64'h24020002_24010001, 2'b11, 1'b0, 32'h0, 1'b1,
                2'b11, 5'd2, 1'b1, 32'hBFC00000, 32'hBFC00004, 32'h24010001};
    tbl[2]  = '{1'b1, 1'b0, 64'h0, 2'b00, 1'b0, 32'h0, 1'b1, 2'b00, 5'd0, 1'b1, 32'h0, 32'h0, 32'h0};
    tbl[3]  = '{1'b0, 1'b0, 64'h0, 2'b00, 1'b0, 32'h0, 1'b0, 2'b00, 5'd0, 1'b1, 32'h0, 32'h0, 32'h0};
    tbl[4]  = '{1'b1, 1'b1, 64'h0_11111111, 2'b01, 1'b0, 32'h0, 1'b0,
                2'b01, 5'd1, 1'b1, 32'hBFC00000, 32'h0, 32'h11111111};
    tbl[5]  = '{1'b1, 1'b1, 64'h0_22222222, 2'b01, 1'b0, 32'h0, 1'b0,
                2'b11, 5'd2, 1'b1, 32'hBFC00000, 32'hBFC00004, 32'h11111111};
    tbl[6]  = '{1'b1, 1'b1, 64'h0_33333333, 2'b01, 1'b0, 32'h0, 1'b0,
                2'b11, 5'd3, 1'b1, 32'hBFC00000, 32'hBFC00004, 32'h11111111};
    tbl[7]  = '{1'b1, 1'b0, 64'h0, 2'b00, 1'b0, 32'h0, 1'b1,
                2'b01, 5'd1, 1'b1, 32'hBFC00008, 32'h0, 32'h33333333};
    tbl[8]  = '{1'b1, 1'b1, 64'hDEADBEEF_DEADBEEF, 2'b00, 1'b0, 32'h0, 1'b0,
                2'b01, 5'd1, 1'b1, 32'hBFC00008, 32'h0, 32'h33333333};
    tbl[9]  = '{1'b1, 1'b0, 64'h0, 2'b00, 1'b0, 32'h0, 1'b1, 2'b00, 5'd0, 1'b1, 32'h0, 32'h0, 32'h0};
    tbl[10] = '{1'b1, 1'b1, 64'h99999999_99999999, 2'b11, 1'b1, 32'h80001000, 1'b1,
                2'b00, 5'd0, 1'b1, 32'h0, 32'h0, 32'h0};
    tbl[11] = '{1'b1, 1'b1, 64'hAAAA0002_AAAA0001, 2'b11, 1'b0, 32'h0, 1'b0,
                2'b11, 5'd2, 1'b1, 32'h80001000, 32'h80001004, 32'hAAAA0001};
    tbl[12] = '{1'b0, 1'b1, 64'h12345678_12345678, 2'b11, 1'b0, 32'h0, 1'b1,
                2'b00, 5'd0, 1'b1, 32'h0, 32'h0, 32'h0};
    tbl[13] = '{1'b1, 1'b1, 64'hBBBB0002_BBBB0001, 2'b11, 1'b0, 32'h0, 1'b0,
                2'b11, 5'd2, 1'b1, 32'hBFC00000, 32'hBFC00004, 32'hBBBB0001};

    drive(1'b0, 1'b0, 64'h0, 2'b00, 1'b0, 32'h0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    model_reset();

    for (int r = 0; r < 14; r++) begin
      drive(tbl[r].r, tbl[r].fv, tbl[r].inst, tbl[r].mask, tbl[r].rv, tbl[r].rpc, tbl[r].ordy);
      tick($sformatf("vec%0d", r));
      chk($sformatf("vec%0d out_valid", r), 64'(out_valid), 64'(tbl[r].e_v));
      chk($sformatf("vec%0d occupancy", r), 64'(occupancy), 64'(tbl[r].e_occ));
      chk($sformatf("vec%0d fill_ready", r), 64'(fill_ready), 64'(tbl[r].e_fr));
      chk($sformatf("vec%0d pc0", r), 64'(out_pc[31:0]), 64'(tbl[r].e_pc0));
      chk($sformatf("vec%0d pc1", r), 64'(out_pc[63:32]), 64'(tbl[r].e_pc1));
      chk($sformatf("vec%0d inst0", r), 64'(out_inst[31:0]), 64'(tbl[r].e_inst0));
    end

    // Fill to full across a pointer wrap, drop a fill while full, then drain.
    drive(1'b0, 1'b0, 64'h0, 2'b00, 1'b0, 32'h0, 1'b0);
    tick("full_rst");
    for (int j = 0; j < 3; j++) begin
      drive(1'b1, 1'b1, {$urandom, $urandom}, 2'b11, 1'b0, 32'h0, 1'b0);
      tick("full_warm");
    end
    drive(1'b1, 1'b0, 64'h0, 2'b00, 1'b0, 32'h0, 1'b1);
    repeat (3) tick("full_warm_drain");
    chk("full warm empty", 64'(occupancy), 64'd0);
    for (int j = 0; j < 8; j++) begin
      drive(1'b1, 1'b1, {32'hC000_0000 + 32'(2*j+1), 32'hC000_0000 + 32'(2*j)}, 2'b11,
            1'b0, 32'h0, 1'b0);
      tick("full_fill");
      if (j == 6) chk("full ready at 14", 64'(fill_ready), 64'd1);
    end
    chk("full occupancy", 64'(occupancy), 64'd16);
    chk("full fill_ready", 64'(fill_ready), 64'd0);
    drive(1'b1, 1'b1, 64'hDEADDEAD_DEADDEAD, 2'b11, 1'b0, 32'h0, 1'b0);
    tick("full_drop");
    chk("full drop occupancy", 64'(occupancy), 64'd16);
    drive(1'b1, 1'b0, 64'h0, 2'b00, 1'b0, 32'h0, 1'b1);
    for (int j = 0; j < 8; j++) begin
      chk($sformatf("drain%0d pc0", j), 64'(out_pc[31:0]), 64'(RPC + 32'd24 + 32'(8*j)));
      chk($sformatf("drain%0d pc1", j), 64'(out_pc[63:32]), 64'(RPC + 32'd28 + 32'(8*j)));
      chk($sformatf("drain%0d inst0", j), 64'(out_inst[31:0]), 64'(32'hC000_0000 + 32'(2*j)));
      tick("full_drain");
    end
    chk("drain empty", 64'(occupancy), 64'd0);

    // Redirect with six entries queued, plus a same-cycle fill and dequeue.
    drive(1'b0, 1'b0, 64'h0, 2'b00, 1'b0, 32'h0, 1'b0);
    tick("redir_rst");
    drive(1'b1, 1'b1, 64'h55550002_55550001, 2'b11, 1'b0, 32'h0, 1'b0);
    repeat (3) tick("redir_fill");
    chk("redir occ6", 64'(occupancy), 64'd6);
    drive(1'b1, 1'b1, 64'h66660002_66660001, 2'b11, 1'b1, 32'h80001000, 1'b1);
    tick("redir");
    chk("redir occupancy", 64'(occupancy), 64'd0);
    chk("redir out_valid", 64'(out_valid), 64'd0);
    drive(1'b1, 1'b1, 64'h77770002_77770001, 2'b11, 1'b0, 32'h0, 1'b0);
    tick("redir_next");
    chk("redir next pc0", 64'(out_pc[31:0]), 64'h80001000);
    chk("redir next pc1", 64'(out_pc[63:32]), 64'h80001004);

    // Steady streaming at four entries, then reset mid-stream.
    drive(1'b0, 1'b0, 64'h0, 2'b00, 1'b0, 32'h0, 1'b0);
    tick("stream_rst");
    drive(1'b1, 1'b1, 64'h0, 2'b11, 1'b0, 32'h0, 1'b0);
    repeat (2) tick("stream_prime");
    chk("stream occ4", 64'(occupancy), 64'd4);
    for (int c = 0; c < 20; c++) begin
      drive(1'b1, 1'b1, {$urandom, $urandom}, 2'b11, 1'b0, 32'h0, 1'b1);
      tick("stream");
      exp_pc0 = RPC + 32'(8*(c+1));
      chk($sformatf("stream%0d occ", c), 64'(occupancy), 64'd4);
      chk($sformatf("stream%0d pc0", c), 64'(out_pc[31:0]), 64'(exp_pc0));
      chk($sformatf("stream%0d pc1", c), 64'(out_pc[63:32]), 64'(exp_pc0 + 32'd4));
    end
    drive(1'b0, 1'b1, 64'h0, 2'b11, 1'b0, 32'h0, 1'b1);
    tick("stream_midrst");
    chk("midrst occupancy", 64'(occupancy), 64'd0);
    drive(1'b1, 1'b1, 64'h0, 2'b11, 1'b0, 32'h0, 1'b0);
    tick("midrst_fill");
    chk("midrst pc0", 64'(out_pc[31:0]), 64'(RPC));

    // Performance counters: 5 cycles empty, then 3 cycles stalled.
    drive(1'b0, 1'b0, 64'h0, 2'b00, 1'b0, 32'h0, 1'b0);
    tick("perf_rst");
    drive(1'b1, 1'b0, 64'h0, 2'b00, 1'b0, 32'h0, 1'b0);
    repeat (4) tick("perf_idle");
    drive(1'b1, 1'b1, 64'h0, 2'b11, 1'b0, 32'h0, 1'b0);
    tick("perf_fill");
    drive(1'b1, 1'b0, 64'h0, 2'b00, 1'b0, 32'h0, 1'b0);
    repeat (3) tick("perf_stall");
    chk("perf_empty_cycles", 64'(perf_empty_cycles), 64'(EXP_EMPTY));
    chk("perf_stall_cycles", 64'(perf_stall_cycles), 64'(EXP_STALL));

    // Random traffic, alternating between fill-heavy and drain-heavy phases.
    for (int c = 0; c < 800; c++) begin
      mk = $urandom_range(2);
      rmask = (mk == 0) ? 2'b00 : ((mk == 1) ? 2'b01 : 2'b11);
      drive(($urandom_range(63) != 0), ($urandom_range(9) < 6), {$urandom, $urandom}, rmask,
            ($urandom_range(15) == 0), ($urandom & 32'hFFFFFFFC),
            (((c / 100) % 2) == 0) ? ($urandom_range(3) == 0) : ($urandom_range(3) != 0));
      tick("rand");
    end
    #1;
    check_model("final");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/inst_stream_feeder.md
Name: inst_stream_feeder

Overview:
- Parametrised instruction supply buffer between the fetch source (ICache or bench fill harness) and the decode stage.
- Accepts groups of up to FETCH_WIDTH instructions per cycle and tags each with a sequential PC.
- Queues instructions in a circular buffer and presents up to FETCH_WIDTH in-order instructions per cycle to decode through a valid/ready handshake.
- Supports redirect (flush plus new PC). Replaces the fixed single-instruction, free-running PC feed used so far.

Parameters:
- FETCH_WIDTH, 2, instructions per fill group and per output group (1..4).
- DEPTH, 16, buffer entries; power of two, and DEPTH >= 2*FETCH_WIDTH.
- RESET_PC, 32'hBFC00000, PC assigned to the first instruction after reset.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-low reset (asserted when 0, sampled on posedge clk).
- fill_valid  in  1  fill group present.
- fill_inst  in  32*FETCH_WIDTH  instructions; slot i is bits [32*i+31:32*i].
- fill_mask  in  FETCH_WIDTH  per-slot valid; must be contiguous from bit 0.
- fill_ready  out  1  buffer can take a full group.
- redirect_valid  in  1  flush buffer and restart PC.
- redirect_pc  in  32  new PC; must be word aligned.
- out_valid  out  FETCH_WIDTH  per-slot valid to decode; contiguous from bit 0.
- out_inst  out  32*FETCH_WIDTH  instructions to decode.
- out_pc  out  32*FETCH_WIDTH  PC of each output slot.
- out_ready  in  1  decode accepts all valid slots this cycle.
- occupancy  out  $clog2(DEPTH)+1  current entry count.
- perf_empty_cycles  out  32  see Optional Feature.
- perf_stall_cycles  out  32  see Optional Feature.

Behaviour:
- Reset (rst==0 at posedge):
  - head, tail and count = 0; next_pc = RESET_PC; perf counters = 0.
  - Outputs next cycle: out_valid=0, fill_ready=1, occupancy=0.
  - Reset overrides all other inputs, including mid-stream.
- Storage:
  - Circular buffer of {inst[31:0], pc[31:0]} entries.
  - head/tail are $clog2(DEPTH)-bit pointers that wrap modulo DEPTH.
  - A separate count register distinguishes full from empty.
- fill_ready = (count <= DEPTH - FETCH_WIDTH), computed combinationally from registered count only; it does not depend on a same-cycle dequeue.
- Enqueue:
  - When fill_valid && fill_ready && !redirect_valid, write n = popcount(fill_mask) entries at tail..tail+n-1.
  - Entry k gets pc = next_pc + 4*k.
  - Then tail += n and next_pc += 4*n (32-bit wrap).
  - fill_valid while !fill_ready: group is dropped, no state change; the source must hold it.
  - fill_mask = 0 with fill_valid: no-op.
- Output (combinational from buffer):
  - out_valid[i] = (count > i); slot i shows entry head+i (mod DEPTH).
  - Invalid slots drive out_inst=0 and out_pc=0.
- Dequeue:
  - When out_ready && out_valid[0] && !redirect_valid, remove m = min(count, FETCH_WIDTH) entries; head += m.
  - Decode must accept the whole valid group; partial acceptance is not supported.
- Simultaneous enqueue and dequeue: count_next = count + n - m. Never overflows, because fill_ready guarantees room before the dequeue.
- Redirect (highest priority below reset):
  - At posedge: head = tail = count = 0; next_pc = redirect_pc.
  - Same-cycle fill and dequeue are ignored.
  - out_valid is 0 the following cycle.
  - A fill in the cycle after redirect gets pc = redirect_pc.
- Latency: an instruction filled at edge t is visible on out_* in the cycle after t. No bypass from fill to out in the same cycle.
- occupancy = count.

Optional Feature:
- Macro: FEEDER_PERF_EN
- Defined:
  - perf_empty_cycles increments every cycle with rst==1 and count==0.
  - perf_stall_cycles increments every cycle with out_valid[0] && !out_ready.
  - Both are 32-bit, saturate at 32'hFFFFFFFF, clear on reset, and are not cleared by redirect.
- Not defined: both ports are tied to 32'h0 and no counter flops exist. The port list is unchanged.

Test Plan:
- Reset, then one fill {0x24010001, 0x24020002} with mask 2'b11; out_ready=1 -> next cycle out_valid=2'b11, out_pc={0xBFC00004, 0xBFC00000}; the following cycle occupancy=0 and out_valid=0.
- Hold out_ready=0 and fill 8 full groups (FETCH_WIDTH=2, DEPTH=16) -> fill_ready drops once count=16; a 9th fill is dropped; occupancy=16; drain yields PCs 0xBFC00000..0xBFC0003C in order across the pointer wrap.
- Fill with mask 2'b01 three times -> PCs 0xBFC00000, 04, 08; out_valid=2'b11 followed by 2'b01.
- With count=6, assert redirect_valid, redirect_pc=0x80001000, together with fill_valid and out_ready -> next cycle occupancy=0 and out_valid=0; the next fill's slot 0 pc=0x80001000.
- Simultaneous fill (2) and dequeue (2) for 20 cycles from count=4 -> occupancy stays 4 and PCs are strictly +4 sequential; then pull rst=0 mid-stream -> next cycle occupancy=0 and the next fill pc=0xBFC00000.
- With FEEDER_PERF_EN: 5 idle cycles then 3 cycles with out_ready=0 and data present -> perf_empty_cycles=5, perf_stall_cycles=3. Without the macro both read 0.
